// File: rtl/serial_transmit_queue_if.sv
// Handshake bundle for serial_transmit_queue: push side, status, and UART byte side.
// The queue itself takes the slave modport; whoever feeds it and the UART takes master.
interface serial_transmit_queue_if #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                    send;
    logic [8*WORD_BYTES-1:0] word;
    logic                    full;
    logic                    busy;
    logic [LW-1:0]           level;
    logic [7:0]              drop_count;
    logic [7:0]              tx_byte;
    logic                    tx_start;
    logic                    uart_ready;

    modport slave (
        input  send, word, uart_ready,
        output full, busy, level, drop_count, tx_byte, tx_start
    );

    modport master (
        output send, word, uart_ready,
        input  full, busy, level, drop_count, tx_byte, tx_start
    );
endinterface

// File: rtl/serial_transmit_queue.sv
// FIFO of found-nonce words serialised MSB byte first onto a byte-wide UART start/ready handshake.
// Optional SERIAL_TX_DEDUP_EN: discard a push equal to the last accepted word.
module serial_transmit_queue #(
    parameter int WORD_BYTES  = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_transmit_queue_if.slave q
);
    localparam int WW = 8 * WORD_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, START, HOLD} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level_r, level_nxt;
    logic          full_r;
    logic [7:0]    drops;
    logic [WW-1:0] shift;
    logic [IW-1:0] idx;
    logic [3:0]    hold_cnt;
    logic [7:0]    tx_byte_r;
    logic          tx_start_r;
    logic          push, pop, drop, dup;
    logic          hold_done, last_byte;

`ifdef SERIAL_TX_DEDUP_EN
    logic [WW-1:0] last_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     last_word <= '0;
        else if (push) last_word <= q.word;
    end

    assign dup = (q.word == last_word);
`else
    assign dup = 1'b0;
`endif

    // A full queue rejects the push even when LOAD frees a slot on the same edge.
    assign push = q.send & ~full_r & ~dup;
    assign drop = q.send & full_r;
    assign pop  = (state == LOAD);

    always_comb begin
        level_nxt = level_r;
        if (push && !pop)      level_nxt = level_r + 1'b1;
        else if (pop && !push) level_nxt = level_r - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            full_r  <= 1'b0;
            drops   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level_r <= level_nxt;
            full_r  <= (level_nxt == (AW+1)'(FIFO_DEPTH));
            if (drop && drops != 8'hFF) drops <= drops + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= q.word;
    end

    assign hold_done = (hold_cnt == 4'(HOLD_CYCLES - 1));
    assign last_byte = (idx == IW'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (level_r != '0) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (q.uart_ready) state_nxt = START;
            START:   state_nxt = HOLD;
            HOLD:    if (hold_done) state_nxt = last_byte ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // tx_byte/tx_start are registered on the WAIT->START edge so the byte is valid during the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift      <= '0;
            idx        <= '0;
            hold_cnt   <= '0;
            tx_byte_r  <= '0;
            tx_start_r <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state)
                LOAD: begin
                    shift <= mem[rd_ptr];
                    idx   <= '0;
                end
                WAIT: if (q.uart_ready) begin
                    tx_byte_r  <= shift[WW-1 -: 8];
                    shift      <= shift << 8;
                    tx_start_r <= 1'b1;
                end
                START: hold_cnt <= '0;
                HOLD: begin
                    if (hold_done) begin
                        hold_cnt <= '0;
                        if (!last_byte) idx <= idx + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q.full       = full_r;
    assign q.busy       = (level_r != '0) || (state != IDLE);
    assign q.level      = level_r;
    assign q.drop_count = drops;
    assign q.tx_byte    = tx_byte_r;
    assign q.tx_start   = tx_start_r;
endmodule

// File: tb/tb_serial_transmit_queue.sv
// Scoreboard bench for serial_transmit_queue: expected bytes queued at push time, popped on tx_start.
module tb_serial_transmit_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_bytes = 0;
    logic prev_start = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    serial_transmit_queue_if #(.WORD_BYTES(4), .FIFO_DEPTH(4)) q ();

    serial_transmit_queue #(.WORD_BYTES(4), .FIFO_DEPTH(4), .HOLD_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endfunction

    task automatic push1(input logic [31:0] w);
        q.send = 1'b1;
        q.word = w;
        @(negedge clk);
        q.send = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk); #1;
            if (!q.busy && exp_q.size() == 0) break;
        end
        chk({tag, "_drain_done"}, k < 500, 1);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
    endtask

    // Byte monitor: every start pulse must match the next expected byte and never repeat back-to-back.
    always @(negedge clk) begin
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (q.tx_start) begin
                n_bytes++;
                chk("start_gap", prev_start, 0);
                chk("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("tx_byte", q.tx_byte, exp_q.pop_front());
            end
            prev_start = q.tx_start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, k;
        int lvl_exp[3] = '{1, 2, 2};
        logic [31:0] burst[3] = '{32'h11111111, 32'h22222222, 32'h33333333};

        q.send = 1'b0;
        q.word = '0;
        q.uart_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_level", q.level, 0);
        chk("rst_full", q.full, 0);
        chk("rst_busy", q.busy, 0);
        chk("rst_tx_start", q.tx_start, 0);
        chk("rst_tx_byte", q.tx_byte, 0);
        chk("rst_drop", q.drop_count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single word: start pulse on the third edge after the push edge
        exp_word(32'hDEADBEEF);
        push1(32'hDEADBEEF);
        chk("t1_busy", q.busy, 1);
        chk("t1_level", q.level, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("t1_latency", q.tx_start, (i == 3));
        end
        drain("t1");
        chk("t1_busy_low", q.busy, 0);

        // Burst: the first word is popped on the third push edge, so occupancy goes 1,2,2
        for (int i = 0; i < 3; i++) begin
            exp_word(burst[i]);
            q.send = 1'b1;
            q.word = burst[i];
            @(negedge clk);
            chk("t2_level", q.level, lvl_exp[i]);
        end
        q.send = 1'b0;
        drain("t2");
        chk("t2_drop", q.drop_count, 0);

        // Overflow: serialiser parks a lead word in WAIT, then six pushes hit a 4-deep queue
        q.uart_ready = 1'b0;
        exp_word(32'h0BADC0DE);
        push1(32'h0BADC0DE);
        repeat (4) @(negedge clk);
        chk("t3_lead_popped", q.level, 0);
        chk("t3_stalled_busy", q.busy, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_word(32'h10000000 + i);
            q.send = 1'b1;
            q.word = 32'h10000000 + i;
            @(negedge clk);
            chk("t3_full", q.full, (i >= 3));
        end
        q.send = 1'b0;
        chk("t3_drop", q.drop_count, 2);
        chk("t3_level", q.level, 4);

        // Full + pop edge: keep pushing while full; the push on the LOAD edge is still dropped
        q.uart_ready = 1'b1;
        q.send = 1'b1;
        q.word = 32'hFFFF0000;
        n = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            if (q.level != 4) break;
        end
        q.send = 1'b0;
        chk("t4_pop_seen", k < 200, 1);
        chk("t4_level", q.level, 3);
        chk("t4_drop", q.drop_count, 2 + n);
        drain("t4");

        // Reset mid-word: word abandoned, nothing resumes afterwards
        exp_word(32'hCAFEF00D);
        base = n_bytes;
        push1(32'hCAFEF00D);
        for (k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (n_bytes >= base + 2) break;
        end
        chk("t5_two_bytes", k < 200, 1);
        reset = 1'b1;
        #1;
        chk("t5_tx_start", q.tx_start, 0);
        chk("t5_level", q.level, 0);
        chk("t5_busy", q.busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base = n_bytes;
        repeat (40) @(negedge clk);
        chk("t5_no_resume", n_bytes - base, 0);
        chk("t5_drop", q.drop_count, 0);
        exp_word(32'hCAFEF00D);
        push1(32'hCAFEF00D);
        drain("t5");

        // Repeated word: discarded only when dedup is built in
        base = n_bytes;
        exp_word(32'hA5A5A5A5);
        push1(32'hA5A5A5A5);
`ifndef SERIAL_TX_DEDUP_EN
        exp_word(32'hA5A5A5A5);
`endif
        push1(32'hA5A5A5A5);
        exp_word(32'h5A5A5A5A);
        push1(32'h5A5A5A5A);
        drain("t6");
        chk("t6_drop", q.drop_count, 0);
`ifdef SERIAL_TX_DEDUP_EN
        chk("t6_byte_count", n_bytes - base, 8);
`else
        chk("t6_byte_count", n_bytes - base, 12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
